batch_scheduler: RTL

Sequencer for the batch-mode control-bounded filter datapath. It generates every address and control strobe that the batch pipeline needs:
- write address into the 4-slot circular sample memory;
- three read addresses: lookahead reverse, compute forward and compute backward;
- write and read addresses for the 2-slot partial-result memories;
- the recursion-load strobe and an output-valid flag.

It replaces the ad-hoc counters in the batch top level. It advances once per downsampled sample tick.

---
 rtl/batch_scheduler_if.sv | 66 ++++++
 rtl/batch_scheduler.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/batch_scheduler_if.sv
// rtl/batch_scheduler_if.sv - tick input and address/strobe bundle of batch_scheduler
//
// Parameter DEPTH must match the scheduler it is connected to.
// Modport master (scheduler side):
//   in : en              downsampled sample tick
//   in : stall           tick suppression (BATCH_SCHED_STALL_EN only)
//   out: samp_addr_in    sample memory write address {cnt, slot_wr}
//   out: samp_addr_lh    lookahead read address {rev, slot_lh}
//   out: samp_addr_fr    forward compute read address {cnt, slot_calc}
//   out: samp_addr_br    backward compute read address {rev, slot_calc}
//   out: res_addr_in     partial-result write address
//   out: res_addr_out_f  forward partial-result read address
//   out: res_addr_out_b  backward partial-result read address
//   out: rec_load        one-tick recursion load strobe
//   out: batch_end       high while cnt == DEPTH-1
//   out: out_valid       final output stream is meaningful
//   out: overrun         sticky stall-at-wrap flag (BATCH_SCHED_STALL_EN only)
// Modport slave is the mirror image for the pipeline side.
interface batch_scheduler_if #(
   parameter int DEPTH = 32
) ();
   localparam int CW = $clog2(DEPTH);

   logic          en;
   logic [CW+1:0] samp_addr_in;
   logic [CW+1:0] samp_addr_lh;
   logic [CW+1:0] samp_addr_fr;
   logic [CW+1:0] samp_addr_br;
   logic [CW:0]   res_addr_in;
   logic [CW:0]   res_addr_out_f;
   logic [CW:0]   res_addr_out_b;
   logic          rec_load;
   logic          batch_end;
   logic          out_valid;

`ifdef BATCH_SCHED_STALL_EN
   logic          stall;
   logic          overrun;

   modport master (
      input  en, stall,
      output samp_addr_in, samp_addr_lh, samp_addr_fr, samp_addr_br,
      output res_addr_in, res_addr_out_f, res_addr_out_b,
      output rec_load, batch_end, out_valid, overrun
   );
   modport slave (
      output en, stall,
      input  samp_addr_in, samp_addr_lh, samp_addr_fr, samp_addr_br,
      input  res_addr_in, res_addr_out_f, res_addr_out_b,
      input  rec_load, batch_end, out_valid, overrun
   );
`else
   modport master (
      input  en,
      output samp_addr_in, samp_addr_lh, samp_addr_fr, samp_addr_br,
      output res_addr_in, res_addr_out_f, res_addr_out_b,
      output rec_load, batch_end, out_valid
   );
   modport slave (
      output en,
      input  samp_addr_in, samp_addr_lh, samp_addr_fr, samp_addr_br,
      input  res_addr_in, res_addr_out_f, res_addr_out_b,
      input  rec_load, batch_end, out_valid
   );
`endif
endinterface

// File: rtl/batch_scheduler.sv
// rtl/batch_scheduler.sv - address and strobe sequencer for the batch filter pipeline
//
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high (wins over en)
//   bus  batch_scheduler_if.master: en in, sample/result addresses,
//        rec_load, batch_end, out_valid out
// Parameters:
//   DEPTH       batch length, power of two, >= 2
//   RES_WR_DLY  ticks from sample state to partial-result write address
//   RES_RD_DLY  ticks from sample state to partial-result read address,
//               1 <= RES_RD_DLY < RES_WR_DLY
// Optional feature macro BATCH_SCHED_STALL_EN: adds bus.stall (suppresses
// a tick) and bus.overrun (sticky, set by a stall on a wrap tick).
module batch_scheduler #(
   parameter int DEPTH      = 32,
   parameter int RES_WR_DLY = 3,
   parameter int RES_RD_DLY = 2
) (
   input  logic clk,
   input  logic rst,
   batch_scheduler_if.master bus
);
   localparam int CW = $clog2(DEPTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH - 1);
   // The live value is delay stage 0 and the output register is the last
   // stage, so only the stages in between need storage.
   localparam int DL_N   = RES_WR_DLY - 1;
   localparam int RD_IDX = (RES_RD_DLY >= 2) ? RES_RD_DLY - 2 : 0;
   localparam int RV_N   = (RES_RD_DLY >= 2) ? RES_RD_DLY - 1 : 1;

   logic [CW-1:0] cnt;
   logic [CW-1:0] rev;
   logic [1:0]    slot_wr, slot_lh, slot_idle, slot_calc;
   logic [1:0]    fill;
   logic          be_q;
   logic          rec_load_q;
   logic          out_valid_q;
   logic [CW+1:0] a_in, a_lh, a_fr, a_br;
   logic [CW:0]   a_res_in, a_res_f, a_res_b;

   logic [CW-1:0] cnt_dl  [DL_N];
   logic          sl_dl   [DL_N];
   logic          full_dl [DL_N];
   logic [CW-1:0] rev_dl  [RV_N];

   logic          tick;
   logic          batch_end;
   logic [CW-1:0] rd_cnt;
   logic [CW-1:0] rd_rev;
   logic          rd_sl;

   assign rev       = CNT_MAX - cnt;
   assign batch_end = (cnt == CNT_MAX);

`ifdef BATCH_SCHED_STALL_EN
   logic overrun_q;

   assign tick        = bus.en & ~bus.stall;
   assign bus.overrun = overrun_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else if (bus.en && bus.stall && batch_end) begin
         overrun_q <= 1'b1;
      end
   end
`else
   assign tick = bus.en;
`endif

   // Tap feeding the result read addresses, RES_RD_DLY-1 stages back.
   always_comb begin
      rd_cnt = cnt;
      rd_rev = rev;
      rd_sl  = slot_wr[0];
      if (RES_RD_DLY >= 2) begin
         rd_cnt = cnt_dl[RD_IDX];
         rd_rev = rev_dl[RV_N-1];
         rd_sl  = sl_dl[RD_IDX];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         slot_wr     <= 2'd0;
         slot_lh     <= 2'd3;
         slot_idle   <= 2'd2;
         slot_calc   <= 2'd1;
         fill        <= 2'd0;
         be_q        <= 1'b0;
         rec_load_q  <= 1'b0;
         out_valid_q <= 1'b0;
         a_in        <= '0;
         a_lh        <= '0;
         a_fr        <= '0;
         a_br        <= '0;
         a_res_in    <= '0;
         a_res_f     <= '0;
         a_res_b     <= '0;
         for (int k = 0; k < DL_N; k++) begin
            cnt_dl[k]  <= '0;
            sl_dl[k]   <= 1'b0;
            full_dl[k] <= 1'b0;
         end
         for (int k = 0; k < RV_N; k++) begin
            rev_dl[k] <= '0;
         end
      end else if (tick) begin
         // DEPTH is a power of two, so the counter wraps on its own.
         cnt <= cnt + 1'b1;
         if (batch_end) begin
            slot_calc <= slot_idle;
            slot_idle <= slot_lh;
            slot_lh   <= slot_wr;
            slot_wr   <= slot_wr + 2'd1;
            if (fill != 2'd3) begin
               fill <= fill + 2'd1;
            end
         end

         a_in <= {cnt, slot_wr};
         a_lh <= {rev, slot_lh};
         a_fr <= {cnt, slot_calc};
         a_br <= {rev, slot_calc};

         // Two stages so the strobe lines up with cnt=0 on samp_addr_*.
         be_q       <= batch_end;
         rec_load_q <= be_q;

         cnt_dl[0]  <= cnt;
         sl_dl[0]   <= slot_wr[0];
         full_dl[0] <= (fill == 2'd3);
         rev_dl[0]  <= rev;
         for (int k = 1; k < DL_N; k++) begin
            cnt_dl[k]  <= cnt_dl[k-1];
            sl_dl[k]   <= sl_dl[k-1];
            full_dl[k] <= full_dl[k-1];
         end
         for (int k = 1; k < RV_N; k++) begin
            rev_dl[k] <= rev_dl[k-1];
         end

         a_res_in    <= {cnt_dl[DL_N-1], sl_dl[DL_N-1]};
         a_res_f     <= {rd_cnt, ~rd_sl};
         a_res_b     <= {rd_rev, ~rd_sl};
         out_valid_q <= out_valid_q | full_dl[DL_N-1];
      end
   end

   assign bus.samp_addr_in   = a_in;
   assign bus.samp_addr_lh   = a_lh;
   assign bus.samp_addr_fr   = a_fr;
   assign bus.samp_addr_br   = a_br;
   assign bus.res_addr_in    = a_res_in;
   assign bus.res_addr_out_f = a_res_f;
   assign bus.res_addr_out_b = a_res_b;
   assign bus.rec_load       = rec_load_q;
   assign bus.batch_end      = batch_end;
   assign bus.out_valid      = out_valid_q;
endmodule
